// File: rtl/mole_scheduler.sv
// Whack-a-mole round scheduler: paces gap/up timing in ms ticks, picks a random
// hole that never repeats the previous one, and keeps score/miss tallies per game.
module mole_scheduler #(
    parameter int          TICK_DIV   = 100000,
    parameter int          NUM_HOLES  = 6,
    parameter int          UP_MS      = 800,
    parameter int          GAP_MS     = 300,
    parameter int          MAX_ROUNDS = 30,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] hit_btn,
    output logic [2:0]           oval_select,
    output logic                 mole_valid,
    output logic [7:0]           score,
    output logic [7:0]           misses,
    output logic                 game_over,
    output logic                 busy
);

    localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_MS = (UP_MS > GAP_MS) ? UP_MS : GAP_MS;
    localparam int MW     = $clog2(MAX_MS + 1);
    localparam int RW     = $clog2(MAX_ROUNDS + 1);

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [MW-1:0] GAP_LAST  = MW'(GAP_MS - 1);
    localparam logic [MW-1:0] UP_LAST   = MW'(UP_MS - 1);
    localparam logic [RW-1:0] ROUND_END = RW'(MAX_ROUNDS - 1);
    localparam logic [2:0]    NONE      = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_GAP, S_PICK, S_UP, S_DONE} state_t;

    state_t          state, state_n;
    logic [15:0]     lfsr;
    logic [PW-1:0]   presc;
    logic [MW-1:0]   ms;
    logic [RW-1:0]   round;
    logic [2:0]      prev_hole;

    logic                 tick_wrap, gap_done, up_timeout;
    logic                 hit_ok, hit_wrong, up_exit, enter_timed;
    logic [NUM_HOLES-1:0] sel_oh;
    logic [2:0]           cand, pick;
    logic [15:0]          lfsr_next;

    assign lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign tick_wrap  = (presc == PRESC_MAX);
    assign gap_done   = tick_wrap && (ms == GAP_LAST);
    assign up_timeout = tick_wrap && (ms == UP_LAST);

    assign sel_oh    = NUM_HOLES'(1) << oval_select;
    assign hit_ok    = |(hit_btn & sel_oh);
    assign hit_wrong = |(hit_btn & ~sel_oh);
    assign up_exit   = (state == S_UP) && (hit_ok || hit_wrong || up_timeout);

    // Full modulo keeps the pick in range even for NUM_HOLES below 4.
    assign cand = lfsr[2:0] % 3'(NUM_HOLES);
    assign pick = (cand != prev_hole)           ? cand :
                  (cand == 3'(NUM_HOLES - 1))   ? 3'd0 : cand + 3'd1;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE: if (start)    state_n = S_GAP;
            S_GAP:          if (gap_done) state_n = S_PICK;
            S_PICK:                       state_n = S_UP;
            S_UP:           if (up_exit)  state_n = (round == ROUND_END) ? S_DONE : S_GAP;
            default:                      state_n = S_IDLE;
        endcase
    end

    assign enter_timed = (state_n != state) && (state_n == S_GAP || state_n == S_UP);

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr        <= LFSR_SEED;
            presc       <= '0;
            ms          <= '0;
            round       <= '0;
            prev_hole   <= NONE;
            score       <= 8'd0;
            misses      <= 8'd0;
            oval_select <= NONE;
            mole_valid  <= 1'b0;
            game_over   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            lfsr <= lfsr_next;

            if (enter_timed) begin
                presc <= '0;
                ms    <= '0;
            end else if (state == S_GAP || state == S_UP) begin
                if (tick_wrap) begin
                    presc <= '0;
                    ms    <= ms + 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end

            if ((state == S_IDLE || state == S_DONE) && start) begin
                score  <= 8'd0;
                misses <= 8'd0;
                round  <= '0;
            end

            if (state == S_PICK) prev_hole <= pick;

            // A correct press outranks a wrong press or timeout in the same cycle.
            if (up_exit) begin
                round <= round + 1'b1;
                if (hit_ok) begin
                    if (score != 8'hFF) score <= score + 8'd1;
                end else if (misses != 8'hFF) begin
                    misses <= misses + 8'd1;
                end
            end

            oval_select <= (state_n != S_UP)  ? NONE :
                           (state == S_PICK)  ? pick : oval_select;
            mole_valid  <= (state_n == S_UP);
            busy        <= (state_n == S_GAP) || (state_n == S_PICK) || (state_n == S_UP);
            game_over   <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with a small scaled-down timing config and
// an independent LFSR/pick model for the hole sequence.
module tb_mole_scheduler;

    localparam int NH = 6;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [NH-1:0] hit_btn = '0;
    logic [2:0]    oval_select;
    logic          mole_valid, game_over, busy;
    logic [7:0]    score, misses;

    mole_scheduler #(
        .TICK_DIV(4), .NUM_HOLES(NH), .UP_MS(5), .GAP_MS(3),
        .MAX_ROUNDS(2), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .hit_btn(hit_btn),
        .oval_select(oval_select), .mole_valid(mole_valid), .score(score),
        .misses(misses), .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0]  exp_prev = 3'b111;
    logic [15:0] m_lfsr = SEED;
    logic [15:0] m_prev = SEED;

    // Reference Galois LFSR for x^16+x^14+x^13+x^11+1; m_prev is the value the
    // DUT saw on the edge just taken.
    always @(posedge clk) begin
        m_prev <= m_lfsr;
        if (!reset) m_lfsr <= SEED;
        else        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [NH-1:0] sel_oh();
        return NH'(1) << oval_select;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_oval"},   oval_select, 3'b111);
        chk({tag, "_valid"},  mole_valid, 0);
        chk({tag, "_score"},  score, 0);
        chk({tag, "_misses"}, misses, 0);
        chk({tag, "_over"},   game_over, 0);
        chk({tag, "_busy"},   busy, 0);
    endtask

    task automatic start_game();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_oval", oval_select, 3'b111);
    endtask

    // Called on GAP cycle n0; mole must appear on cycle 14 (12 GAP + 1 PICK).
    task automatic wait_mole(input int n0);
        int n;
        int bad;
        logic [2:0] e;
        n = n0;
        bad = 0;
        while (!mole_valid && n < 100) begin
            if (oval_select !== 3'b111) bad++;
            @(negedge clk);
            n++;
        end
        chk("gap_pick_len", n, 14);
        chk("gap_oval_none", bad, 0);
        chk("mole_valid", mole_valid, 1);
        e = m_prev[2:0];
        if (e >= 3'(NH)) e = e - 3'(NH);
        if (e == exp_prev) e = (e == 3'(NH - 1)) ? 3'd0 : e + 3'd1;
        chk("pick", oval_select, e);
        chk("pick_in_range", oval_select < 3'(NH), 1);
        chk("pick_not_prev", oval_select == exp_prev, 0);
        exp_prev = e;
    endtask

    task automatic press(input logic [NH-1:0] v);
        hit_btn = v;
        @(negedge clk);
        hit_btn = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int m;
        int w;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b1;
        @(negedge clk);
        chk("idle_oval", oval_select, 3'b111);

        // Game 1: correct hit, then a timeout ending the game.
        start_game();
        wait_mole(1);
        press(sel_oh());
        chk("hit_score", score, 1);
        chk("hit_misses", misses, 0);
        chk("hit_oval", oval_select, 3'b111);
        chk("hit_valid", mole_valid, 0);
        chk("hit_busy", busy, 1);
        wait_mole(1);
        m = 0;
        while (mole_valid && m < 50) begin
            m++;
            @(negedge clk);
        end
        chk("up_len", m, 20);
        chk("to_misses", misses, 1);
        chk("to_score", score, 1);
        chk("to_oval", oval_select, 3'b111);
        chk("to_over", game_over, 1);
        chk("to_busy", busy, 0);

        // Game 2 (restart from DONE): correct+wrong together, GAP press, multi-wrong.
        start_game();
        chk("g2_score_clr", score, 0);
        chk("g2_misses_clr", misses, 0);
        chk("g2_over_clr", game_over, 0);
        wait_mole(1);
        w = (int'(oval_select) + 1) % NH;
        press(sel_oh() | (NH'(1) << w));
        chk("both_score", score, 1);
        chk("both_misses", misses, 0);
        chk("both_oval", oval_select, 3'b111);
        hit_btn = '1;
        @(negedge clk);
        hit_btn = '0;
        wait_mole(2);
        chk("gap_ignore", misses, 0);
        press(~sel_oh());
        chk("wrong_misses", misses, 1);
        chk("wrong_score", score, 1);
        chk("wrong_oval", oval_select, 3'b111);
        chk("wrong_valid", mole_valid, 0);
        chk("wrong_over", game_over, 1);

        // Game 3: reset while a mole is up, then a fresh game.
        start_game();
        wait_mole(1);
        press(sel_oh());
        chk("g3_score", score, 1);
        wait_mole(1);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("midup");
        exp_prev = 3'b111;
        reset = 1'b1;
        @(negedge clk);
        start_game();
        wait_mole(1);
        chk("fresh_score", score, 0);
        chk("fresh_misses", misses, 0);
        press(sel_oh());
        wait_mole(1);
        press(sel_oh());
        chk("fresh_final", score, 2);
        chk("fresh_over", game_over, 1);

        // Long run of games exercising the hole sequence.
        for (int g = 0; g < 200; g++) begin
            start_game();
            for (int r = 0; r < 2; r++) begin
                wait_mole(1);
                press(sel_oh());
            end
            chk("loop_score", score, 2);
            chk("loop_over", game_over, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, clk cycles per 1 ms tick.
REQ-002 SHALL have parameter NUM_HOLES, default 6, number of holes (legal 2..7).
REQ-003 SHALL have parameter UP_MS, default 800, ms a mole stays shown.
REQ-004 SHALL have parameter GAP_MS, default 300, ms of empty screen between moles.
REQ-005 SHALL have parameter MAX_ROUNDS, default 30, moles per game.
REQ-006 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-007 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-008 SHALL have port reset  in  1  synchronous, active-low reset (0 = reset).
REQ-009 SHALL have port start  in  1  single-cycle pulse that begins a game.
REQ-010 SHALL have port hit_btn  in  NUM_HOLES  debounced single-cycle press pulses, bit i = hole i.
REQ-011 SHALL have port oval_select  out  3  hole currently shown, 0..NUM_HOLES-1; 3'b111 = none.
REQ-012 SHALL have port mole_valid  out  1  high iff oval_select names a hole.
REQ-013 SHALL have port score  out  8  correct hits this game.
REQ-014 SHALL have port misses  out  8  timeouts plus wrong presses this game.
REQ-015 SHALL have port game_over  out  1  high in DONE.
REQ-016 SHALL have port busy  out  1  high in GAP, PICK, UP.

Function
REQ-017 SHALL implement states IDLE, GAP, PICK, UP, DONE.
REQ-018 IDLE: oval_select=3'b111; start -> clear score, misses, round counter; go GAP.
REQ-019 GAP: SHALL remain exactly GAP_MS*TICK_DIV cycles, then go PICK; hit_btn ignored, no penalty.
REQ-020 PICK: one cycle; candidate = LFSR[2:0], minus NUM_HOLES if >= NUM_HOLES; if candidate equals previous hole, use (candidate+1) mod NUM_HOLES; register into oval_select; go UP.
REQ-021 UP: if hit_btn[oval_select]=1 -> score+1; else if any other hit_btn bit=1 -> misses+1; else if UP_MS*TICK_DIV cycles elapsed in UP -> misses+1.
REQ-022 Any UP-exit event SHALL set oval_select=3'b111 next cycle, increment round, go DONE if round reaches MAX_ROUNDS else GAP.
REQ-023 Correct press SHALL win over simultaneous wrong press and over simultaneous timeout (score only, no miss).
REQ-024 Multiple wrong presses in one cycle SHALL count as one miss.
REQ-025 score and misses SHALL saturate at 255.
REQ-026 Timers: one tick prescaler (0..TICK_DIV-1) and one ms counter, both cleared on every entry to GAP or UP.
REQ-027 LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every clk cycle in all states.
REQ-028 start SHALL be ignored in GAP, PICK, UP; in DONE it restarts as from IDLE.
REQ-029 DONE: oval_select=3'b111, game_over=1, score/misses hold final values.
REQ-030 mole_valid and busy SHALL be registered, consistent with oval_select and state in the same cycle.

Reset
REQ-031 reset=0 at a clock edge SHALL force IDLE from any state, including mid-UP.
REQ-032 Reset values: oval_select=3'b111, mole_valid=0, score=0, misses=0, game_over=0, busy=0, LFSR=LFSR_SEED, timers=0, previous hole=3'b111.

Verification (TICK_DIV=4, UP_MS=5, GAP_MS=3, MAX_ROUNDS=2, NUM_HOLES=6)
REQ-033 start pulse -> busy=1 next cycle; oval_select stays 7 for 12 cycles, PICK 1 cycle, then oval_select in 0..5 with mole_valid=1.
REQ-034 In UP, pulse hit_btn[oval_select] -> score=1, misses=0, oval_select=7 next cycle.
REQ-035 In UP, no press for 20 cycles -> misses=1, oval_select=7 on cycle 21; second round same -> game_over=1, busy=0.
REQ-036 Same cycle: correct bit plus one wrong bit set -> score+1, misses unchanged; wrong bit only -> misses+1, mole removed.
REQ-037 Across 200 games, oval_select never >5 while mole_valid=1 and never equals the previous mole.
REQ-038 reset=0 mid-UP with score=1 -> next cycle all outputs at REQ-032 values; start afterwards begins a fresh game.
